systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001: Parameter N, default 4, number of array rows (one input FIFO per row).
REQ-002: Parameter nbits, default 16, data word width.
REQ-003: Parameter kbits, default 8, width of the inner-dimension length.
REQ-004: clk  input  1  clock; all state SHALL update on posedge clk.
REQ-005: rst  input  1  reset, synchronous, active-high.
REQ-006: start  input  1  one-cycle request to begin one matrix pass.
REQ-007: k_len  input  kbits  words per row for this pass, sampled with start.
REQ-008: fifo_empty  input  N  per-row FIFO empty flags.
REQ-009: fifo_q  input  N*nbits  per-row FIFO read data; row i is bits [i*nbits +: nbits]; valid one cycle after the matching ren.
REQ-010: fifo_ren  output  N  per-row FIFO read enables.
REQ-011: a_out  output  N*nbits  skewed data into array row i, packed as fifo_q.
REQ-012: a_valid  output  N  per-row valid for a_out.
REQ-013: busy  output  1  high while a pass is in progress.
REQ-014: done  output  1  one-cycle pulse at end of pass.

Function
REQ-015: FSM states SHALL be IDLE, RUN and DRAIN.
REQ-016: IDLE: start=1 with k_len!=0 SHALL latch k_len, clear wavefront counter t to 0 and go to RUN.
REQ-017: IDLE: start=1 with k_len=0 SHALL go to DRAIN without issuing any read.
REQ-018: start while busy=1 SHALL be ignored.
REQ-019: Row i is active in RUN when i <= t < i+k; k is the latched k_len.
REQ-020: RUN stall: any active row with fifo_empty=1 -> fifo_ren SHALL be all 0 and t SHALL hold.
REQ-021: RUN advance (no stall): fifo_ren SHALL equal the active mask and t SHALL increment by 1.
REQ-022: fifo_ren SHALL never assert outside RUN or for an inactive row.
REQ-023: t width SHALL be kbits+clog2(N)+1 so that t = k+N-2 cannot wrap.
REQ-024: Advance with t = k+N-2 SHALL transition RUN -> DRAIN.
REQ-025: a_valid[i] SHALL be fifo_ren[i] registered one cycle; a_out row i SHALL equal fifo_q row i when a_valid[i]=1, else 0.
REQ-026: Latency: FIFO read at cycle c appears on a_out/a_valid at cycle c+1.
REQ-027: Skew: row i's j-th word SHALL appear exactly i cycles after row 0's j-th word when no stall occurs.
REQ-028: A stall SHALL delay all rows equally, so that relative skew is preserved.
REQ-029: DRAIN SHALL last one cycle, assert done=1 in that cycle, then return to IDLE.
REQ-030: In DRAIN, a_valid carries the final reads; done SHALL coincide with the last a_valid.
REQ-031: busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-032: Each active row SHALL be read exactly k times per pass.

Reset
REQ-033: rst=1 SHALL force IDLE, clear t, and zero fifo_ren, a_valid, a_out, busy and done on the next edge, including mid-pass.
REQ-034: After rst, a new start SHALL begin a clean pass; no partial-pass state SHALL remain.

Verification
REQ-035: N=4, k_len=3, all FIFOs non-empty, start at cycle 0 -> fifo_ren 0001,0011,0111,1110,1100,1000 at cycles 1-6; a_valid same pattern at cycles 2-7; done=1 only at cycle 7; busy cycles 1-7.
REQ-036: Same pass, row 2 FIFO empty at cycle 3 only -> cycle 3 fifo_ren=0000; ren pattern resumes with 0111 at cycle 4; done at cycle 8; 3 reads per row.
REQ-037: start with k_len=0 -> no fifo_ren; done pulses one cycle later; busy high for that one cycle.
REQ-038: rst asserted at cycle 4 of the REQ-035 pass -> cycle 5 all outputs 0, IDLE; a new start at cycle 6 produces the REQ-035 pattern shifted by 6.
REQ-039: start pulsed again at cycle 3 of a pass -> ignored; total reads per row = 3; a single done pulse.
REQ-040: Row data check: FIFO row i preloaded 10*i+j -> a_out row i yields j=0..k-1 in order, with each row i offset i cycles from row 0.

Source files
------------

// File: rtl/systolic_feeder.sv
// Purpose: pulls k words per row from N row FIFOs and feeds them into a systolic array with an i-cycle skew on row i.
// Latency: a FIFO read issued in cycle c appears on a_out/a_valid in cycle c+1; done coincides with the final a_valid.
// Backpressure: if any active row's FIFO is empty, no row is read and the wavefront holds, so every row stalls together.
module systolic_feeder #(
    parameter int N     = 4,
    parameter int nbits = 16,
    parameter int kbits = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [kbits-1:0]   k_len,
    input  logic [N-1:0]       fifo_empty,
    input  logic [N*nbits-1:0] fifo_q,
    output logic [N-1:0]       fifo_ren,
    output logic [N*nbits-1:0] a_out,
    output logic [N-1:0]       a_valid,
    output logic               busy,
    output logic               done
);

    // Wavefront counter must reach k+N-2 without wrapping.
    localparam int TW = kbits + $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   t_q;
    logic [TW-1:0]   t_d;
    logic [kbits-1:0] k_q;
    logic [N-1:0]    a_valid_q;
    logic            busy_q;
    logic            done_q;

    logic [N-1:0]    active;
    logic            stall;
    logic [TW-1:0]   k_ext;
    logic [TW-1:0]   last_t;

    assign k_ext  = {{(TW-kbits){1'b0}}, k_q};
    assign last_t = k_ext + TW'(N) - TW'(2);
    assign t_d    = t_q + TW'(1);

    // Row i is on the wavefront while i <= t < i+k; stall if any such row has nothing to give.
    always_comb begin
        active = '0;
        stall  = 1'b0;
        for (int i = 0; i < N; i++) begin
            active[i] = (t_q >= TW'(i)) && (t_q < (TW'(i) + k_ext));
            if (active[i] && fifo_empty[i]) begin
                stall = 1'b1;
            end
        end
    end

    // Reads only happen in RUN on an advancing cycle; reset blocks a read in the same cycle so no FIFO word is lost.
    always_comb begin
        fifo_ren = '0;
        if (state_q == RUN && !stall && !rst) begin
            fifo_ren = active;
        end
    end

    // FIFO data arrives one cycle after the read, aligned with the registered valid; zero it otherwise.
    always_comb begin
        a_out = '0;
        for (int i = 0; i < N; i++) begin
            if (a_valid_q[i]) begin
                a_out[i*nbits +: nbits] = fifo_q[i*nbits +: nbits];
            end
        end
    end

    // Pass control FSM with registered valid/busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            t_q       <= '0;
            k_q       <= '0;
            a_valid_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            a_valid_q <= fifo_ren;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (k_len != '0) begin
                            k_q     <= k_len;
                            t_q     <= '0;
                            state_q <= RUN;
                        end else begin
                            // Empty pass: straight to the done cycle, no reads.
                            state_q <= DRAIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        t_q <= t_d;
                        if (t_q == last_t) begin
                            state_q <= DRAIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_valid = a_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Purpose: directed bench for systolic_feeder with a behavioural row-FIFO model and per-cycle expected tables.
// Latency: expectations are indexed by cycle, cycle 0 being the cycle in which start is first driven.
// Backpressure: FIFO empty flags can be forced per cycle to exercise the stall path.
module tb_systolic_feeder;

    localparam int N     = 4;
    localparam int NB    = 16;
    localparam int KB    = 8;
    localparam int DEPTH = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [KB-1:0]     k_len;
    logic [N-1:0]      fifo_empty;
    logic [N*NB-1:0]   fifo_q;
    logic [N-1:0]      fifo_ren;
    logic [N*NB-1:0]   a_out;
    logic [N-1:0]      a_valid;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    // FIFO model: row i holds 10*i + j at position j.
    logic [NB-1:0] q_row [N];
    int            ptr   [N];
    logic          flush;
    logic [N-1:0]  force_emp;

    systolic_feeder #(.N(N), .nbits(NB), .kbits(KB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .k_len      (k_len),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_ren   (fifo_ren),
        .a_out      (a_out),
        .a_valid    (a_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (flush) begin
                ptr[i]   <= 0;
                q_row[i] <= '0;
            end else if (fifo_ren[i]) begin
                q_row[i] <= NB'(10 * i + ptr[i]);
                ptr[i]   <= ptr[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            fifo_q[i*NB +: NB] = q_row[i];
            fifo_empty[i]      = force_emp[i] || (ptr[i] >= DEPTH);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One directed scenario: per-cycle stimulus masks and expected nibble/bit tables (cycle c = nibble/bit c).
    task automatic run(input string nm, input int ncyc,
                       input logic [15:0] st_m, input logic [15:0] rs_m,
                       input logic [KB-1:0] k0, input logic [KB-1:0] k1,
                       input logic [63:0] emp_v, input logic [63:0] ren_v,
                       input logic [63:0] vld_v, input logic [15:0] done_m,
                       input logic [15:0] busy_m, input int r0, input int r1,
                       input int r2, input int r3);
        int recv [N];
        int rcnt [N];
        int rexp [N];
        logic [NB-1:0] ev;
        rexp[0] = r0; rexp[1] = r1; rexp[2] = r2; rexp[3] = r3;
        for (int i = 0; i < N; i++) begin
            recv[i] = 0;
            rcnt[i] = 0;
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start     = st_m[c];
            rst       = rs_m[c];
            k_len     = (c == 0) ? k0 : k1;
            force_emp = emp_v[4*c +: 4];
            #1;
            chk($sformatf("%s c%0d ren", nm, c), 64'(fifo_ren), 64'(ren_v[4*c +: 4]));
            chk($sformatf("%s c%0d vld", nm, c), 64'(a_valid), 64'(vld_v[4*c +: 4]));
            chk($sformatf("%s c%0d done", nm, c), 64'(done), 64'(done_m[c]));
            chk($sformatf("%s c%0d busy", nm, c), 64'(busy), 64'(busy_m[c]));
            for (int i = 0; i < N; i++) begin
                ev = vld_v[4*c + i] ? NB'(10 * i + recv[i]) : '0;
                chk($sformatf("%s c%0d row%0d data", nm, c, i), 64'(a_out[i*NB +: NB]), 64'(ev));
                if (vld_v[4*c + i]) recv[i]++;
                if (fifo_ren[i]) rcnt[i]++;
            end
        end
        @(negedge clk);
        start     = 1'b0;
        rst       = 1'b0;
        force_emp = '0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s reads row%0d", nm, i), 64'(rcnt[i]), 64'(rexp[i]));
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        force_emp = '0;
        flush     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset ren",  64'(fifo_ren), 64'h0);
        chk("reset vld",  64'(a_valid),  64'h0);
        chk("reset aout", 64'(a_out),    64'h0);
        chk("reset busy", 64'(busy),     64'h0);
        chk("reset done", 64'(done),     64'h0);
        rst   = 1'b0;
        flush = 1'b0;

        // Basic k=3 pass, no stalls.
        run("basic", 10, 16'h0001, 16'h0000, 8'd3, 8'd3,
            64'h0, 64'h00000000_08CE7310, 64'h00000000_8CE73100,
            16'h0080, 16'h00FE, 3, 3, 3, 3);

        // Row 2 empty in cycle 3 stalls every row for one cycle.
        run("stall", 11, 16'h0001, 16'h0000, 8'd3, 8'd3,
            64'h00000000_00004000, 64'h00000000_8CE70310, 64'h00000008_CE703100,
            16'h0100, 16'h01FE, 3, 3, 3, 3);

        // Zero-length pass: no reads, one busy/done cycle.
        run("kzero", 4, 16'h0001, 16'h0000, 8'd0, 8'd0,
            64'h0, 64'h0, 64'h0,
            16'h0002, 16'h0002, 0, 0, 0, 0);

        // Reset in cycle 4 aborts the pass; a fresh start in cycle 6 replays it shifted by 6.
        run("midrst", 15, 16'h0041, 16'h0010, 8'd3, 8'd3,
            64'h0, 64'h0008CE73_10007310, 64'h008CE731_00073100,
            16'h2000, 16'h3F9E, 6, 5, 4, 3);

        // A second start (with a different length) during the pass is ignored.
        run("restart", 10, 16'h0009, 16'h0000, 8'd3, 8'd5,
            64'h0, 64'h00000000_08CE7310, 64'h00000000_8CE73100,
            16'h0080, 16'h00FE, 3, 3, 3, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
